// File: rtl/mesh_term_injector.sv
// mesh_term_injector
// ------------------
// Host-side injector for one mesh router terminal. A host request is
// formatted into a router packet and buffered in a show-ahead FIFO that
// the router drains through its terminal input.
//
// Packet layout (PCKG_SZ bits, MSB first):
//   next-jump[8] | row[4] | column[4] | mode[1] | payload[PCKG_SZ-17]
//
// Ports
//   clk_i          single rising-edge clock
//   rst_i          synchronous, active-low reset
//   in_valid       host offers a request
//   in_ready       block can accept a request this cycle (FIFO not full)
//   in_row/in_col  target terminal coordinates
//   in_mode        router routing mode bit
//   in_bcast       request is a broadcast (destination check bypassed)
//   in_payload     payload bits
//   data_out_i_in  head packet toward the router (zero when empty)
//   pndng_i_in     a packet is pending toward the router
//   popin          router consumes the head packet
//   drop_o         one-cycle pulse: last accepted request had a bad target
//   underflow_o    sticky: popin was seen while the FIFO was empty
//
// Optional build macro TERM_INJ_STATS_EN adds 16-bit wrapping counters
//   sent_cnt (packets popped) and drop_cnt (requests dropped).
//
// Handshake: a request transfers on a rising edge where in_valid and
// in_ready are both 1. in_ready does not depend on in_valid or popin, so a
// pop in the same cycle as a full FIFO frees a slot only for the next cycle.
// A transferred request with an invalid target is consumed but not stored.
module mesh_term_injector #(
  parameter int          ROWS       = 4,
  parameter int          COLUMNS    = 4,
  parameter int          PCKG_SZ    = 32,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  BDCST      = 8'hFF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_row,
  input  logic [3:0]         in_col,
  input  logic               in_mode,
  input  logic               in_bcast,
  input  logic [PCKG_SZ-18:0] in_payload,
  output logic [PCKG_SZ-1:0] data_out_i_in,
  output logic               pndng_i_in,
  input  logic               popin,
  output logic               drop_o,
  output logic               underflow_o
`ifdef TERM_INJ_STATS_EN
  ,
  output logic [15:0]        sent_cnt,
  output logic [15:0]        drop_cnt
`endif
);

  localparam int         AW       = $clog2(FIFO_DEPTH);
  localparam int         CW       = AW + 1;
  localparam logic [3:0] ROW_LAST = 4'(ROWS + 1);
  localparam logic [3:0] COL_LAST = 4'(COLUMNS + 1);
  localparam logic [3:0] ROW_MAX  = 4'(ROWS);
  localparam logic [3:0] COL_MAX  = 4'(COLUMNS);

  logic [PCKG_SZ-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;

  logic               full;
  logic               empty;
  logic               row_edge;
  logic               col_edge;
  logic               row_inner;
  logic               col_inner;
  logic               dest_ok;
  logic               push;
  logic               pop;
  logic               bad_req;
  logic [7:0]         next_jump;
  logic [PCKG_SZ-1:0] pkt;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);

  // Terminals sit on the ring just outside the router grid: rows 0 and
  // ROWS+1 carry columns 1..COLUMNS, columns 0 and COLUMNS+1 carry rows
  // 1..ROWS. Corners and interior coordinates have no terminal.
  always_comb begin
    row_edge  = (in_row == 4'd0) || (in_row == ROW_LAST);
    col_edge  = (in_col == 4'd0) || (in_col == COL_LAST);
    row_inner = (in_row != 4'd0) && (in_row <= ROW_MAX);
    col_inner = (in_col != 4'd0) && (in_col <= COL_MAX);
    dest_ok   = in_bcast || (row_edge && col_inner) || (col_edge && row_inner);
  end

  assign next_jump = in_bcast ? BDCST : 8'h00;
  assign pkt       = {next_jump, in_row, in_col, in_mode, in_payload};

  // in_ready is forced low while reset is held so nothing is offered as
  // accepted during reset, independent of the stale occupancy.
  assign in_ready = rst_i & ~full;
  assign push     = in_valid & in_ready & dest_ok;
  assign bad_req  = in_valid & in_ready & ~dest_ok;
  assign pop      = popin & ~empty;

  assign pndng_i_in    = rst_i & ~empty;
  assign data_out_i_in = (rst_i && !empty) ? mem[rd_ptr] : '0;

  // Storage carries no reset: emptiness is owned by count, and the head is
  // masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= pkt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      drop_o      <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      drop_o <= bad_req;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A pop request against an empty FIFO is ignored but remembered,
      // including when a push lands in that same cycle.
      if (popin && empty) begin
        underflow_o <= 1'b1;
      end
    end
  end

`ifdef TERM_INJ_STATS_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sent_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (pop) begin
        sent_cnt <= sent_cnt + 16'd1;
      end
      if (bad_req) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mesh_term_injector.sv
// Directed testbench for mesh_term_injector (default parameters, PCKG_SZ=32).
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// at that same point, well away from the next edge.
module tb_mesh_term_injector;

  localparam int PW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_row;
  logic [3:0]    in_col;
  logic          in_mode;
  logic          in_bcast;
  logic [14:0]   in_payload;
  logic [PW-1:0] data_out_i_in;
  logic          pndng_i_in;
  logic          popin;
  logic          drop_o;
  logic          underflow_o;
`ifdef TERM_INJ_STATS_EN
  logic [15:0]   sent_cnt;
  logic [15:0]   drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int exp_sent = 0;
  int exp_drop = 0;
  logic [PW-1:0] exp_q[$];

  mesh_term_injector dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_row        (in_row),
    .in_col        (in_col),
    .in_mode       (in_mode),
    .in_bcast      (in_bcast),
    .in_payload    (in_payload),
    .data_out_i_in (data_out_i_in),
    .pndng_i_in    (pndng_i_in),
    .popin         (popin),
    .drop_o        (drop_o),
    .underflow_o   (underflow_o)
`ifdef TERM_INJ_STATS_EN
    ,
    .sent_cnt      (sent_cnt),
    .drop_cnt      (drop_cnt)
`endif
  );

  // Clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    popin      = 1'b0;
    in_bcast   = 1'b0;
    in_row     = 4'd0;
    in_col     = 4'd0;
    in_mode    = 1'b0;
    in_payload = '0;
  endtask

  task automatic drive_req(input logic [3:0] r, input logic [3:0] c,
                           input logic m, input logic b,
                           input logic [14:0] p);
    in_valid   = 1'b1;
    in_row     = r;
    in_col     = c;
    in_mode    = m;
    in_bcast   = b;
    in_payload = p;
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1'b0;
    tick();
    tick();
    checks++; if (pndng_i_in !== 1'b0) begin errors++; $display("FAIL reset_pndng: got %b want 0", pndng_i_in); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", in_ready); end
    checks++; if (data_out_i_in !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 00000000", data_out_i_in); end
    checks++; if (drop_o !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b want 0", drop_o); end
    checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b want 0", underflow_o); end
    rst_i = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
`ifdef TERM_INJ_STATS_EN
    checks++; if (sent_cnt !== 16'd0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d want 0/0", sent_cnt, drop_cnt); end
`endif
  endtask

  task automatic test_format();
    drive_req(4'd0, 4'd2, 1'b1, 1'b0, 15'h1234);
    tick();
    idle();
    checks++; if (pndng_i_in !== 1'b1) begin errors++; $display("FAIL fmt_pndng: got %b want 1", pndng_i_in); end
    checks++; if (data_out_i_in !== 32'h0002_9234) begin errors++; $display("FAIL fmt_data: got %h want 00029234", data_out_i_in); end
    checks++; if (drop_o !== 1'b0) begin errors++; $display("FAIL fmt_drop: got %b want 0", drop_o); end
    popin = 1'b1;
    tick();
    popin = 1'b0;
    exp_sent++;
    checks++; if (pndng_i_in !== 1'b0) begin errors++; $display("FAIL fmt_pop_pndng: got %b want 0", pndng_i_in); end
    checks++; if (data_out_i_in !== 32'h0) begin errors++; $display("FAIL fmt_pop_data: got %h want 00000000", data_out_i_in); end
  endtask

  task automatic test_bcast();
    drive_req(4'd9, 4'd9, 1'b0, 1'b1, 15'h7FFF);
    tick();
    idle();
    checks++; if (pndng_i_in !== 1'b1) begin errors++; $display("FAIL bcast_pndng: got %b want 1", pndng_i_in); end
    checks++; if (data_out_i_in !== 32'hFF99_7FFF) begin errors++; $display("FAIL bcast_data: got %h want ff997fff", data_out_i_in); end
    checks++; if (drop_o !== 1'b0) begin errors++; $display("FAIL bcast_drop: got %b want 0", drop_o); end
    popin = 1'b1;
    tick();
    popin = 1'b0;
    exp_sent++;
  endtask

  task automatic test_drop();
    logic [3:0] rows [7] = '{4'd2, 4'd5, 4'd0, 4'd1, 4'd0, 4'd4, 4'd5};
    logic [3:0] cols [7] = '{4'd2, 4'd4, 4'd0, 4'd5, 4'd5, 4'd0, 4'd5};
    logic       oks  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] exp_pkt;
    for (int i = 0; i < 7; i++) begin
      drive_req(rows[i], cols[i], 1'b0, 1'b0, 15'(i + 1));
      tick();
      idle();
      checks++; if (drop_o !== !oks[i]) begin errors++; $display("FAIL drop_pulse[%0d]: got %b want %b", i, drop_o, !oks[i]); end
      checks++; if (pndng_i_in !== oks[i]) begin errors++; $display("FAIL drop_pndng[%0d]: got %b want %b", i, pndng_i_in, oks[i]); end
      if (oks[i]) begin
        exp_pkt = {8'h00, rows[i], cols[i], 1'b0, 15'(i + 1)};
        checks++; if (data_out_i_in !== exp_pkt) begin errors++; $display("FAIL drop_data[%0d]: got %h want %h", i, data_out_i_in, exp_pkt); end
        popin = 1'b1;
        tick();
        popin = 1'b0;
        exp_sent++;
      end else begin
        exp_drop++;
        tick();
        checks++; if (drop_o !== 1'b0) begin errors++; $display("FAIL drop_one_cycle[%0d]: got %b want 0", i, drop_o); end
      end
    end
`ifdef TERM_INJ_STATS_EN
    checks++; if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL drop_cnt: got %0d want %0d", drop_cnt, exp_drop); end
    checks++; if (sent_cnt !== 16'(exp_sent)) begin errors++; $display("FAIL sent_cnt_drop: got %0d want %0d", sent_cnt, exp_sent); end
`endif
  endtask

  task automatic test_fill();
    logic [31:0] exp_pkt;
    for (int i = 0; i < 16; i++) begin
      exp_pkt = {8'h00, 4'd0, 4'(1 + (i % 4)), 1'b0, 15'(i * 3 + 100)};
      drive_req(4'd0, 4'(1 + (i % 4)), 1'b0, 1'b0, 15'(i * 3 + 100));
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d]: got %b want 1", i, in_ready); end
      tick();
      exp_q.push_back(exp_pkt);
    end
    idle();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", in_ready); end
    checks++; if (data_out_i_in !== exp_q[0]) begin errors++; $display("FAIL full_head: got %h want %h", data_out_i_in, exp_q[0]); end
    // 17th offer together with a pop: the freed slot is not usable yet
    drive_req(4'd0, 4'd1, 1'b1, 1'b0, 15'h7777);
    popin = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready: got %b want 0", in_ready); end
    tick();
    idle();
    void'(exp_q.pop_front());
    exp_sent++;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL after_pop_ready: got %b want 1", in_ready); end
    for (int k = 0; k < 15; k++) begin
      exp_pkt = exp_q.pop_front();
      checks++; if (pndng_i_in !== 1'b1 || data_out_i_in !== exp_pkt) begin errors++; $display("FAIL drain_order[%0d]: got %b/%h want 1/%h", k, pndng_i_in, data_out_i_in, exp_pkt); end
      popin = 1'b1;
      tick();
      popin = 1'b0;
      exp_sent++;
    end
    checks++; if (pndng_i_in !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", pndng_i_in); end
`ifdef TERM_INJ_STATS_EN
    checks++; if (sent_cnt !== 16'(exp_sent)) begin errors++; $display("FAIL sent_cnt_fill: got %0d want %0d", sent_cnt, exp_sent); end
`endif
  endtask

  task automatic test_back_to_back();
    drive_req(4'd0, 4'd1, 1'b0, 1'b0, 15'h0001);
    tick();
    drive_req(4'd0, 4'd2, 1'b0, 1'b0, 15'h0002);
    tick();
    drive_req(4'd0, 4'd3, 1'b0, 1'b0, 15'h0003);
    popin = 1'b1;
    tick();
    idle();
    checks++; if (data_out_i_in !== 32'h0002_0002) begin errors++; $display("FAIL b2b_head_b: got %h want 00020002", data_out_i_in); end
    popin = 1'b1;
    tick();
    popin = 1'b0;
    checks++; if (pndng_i_in !== 1'b1 || data_out_i_in !== 32'h0003_0003) begin errors++; $display("FAIL b2b_head_c: got %b/%h want 1/00030003", pndng_i_in, data_out_i_in); end
    popin = 1'b1;
    tick();
    popin = 1'b0;
    exp_sent += 3;
    checks++; if (pndng_i_in !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", pndng_i_in); end
  endtask

  task automatic test_underflow();
    checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL uf_before: got %b want 0", underflow_o); end
    popin = 1'b1;
    tick();
    popin = 1'b0;
    checks++; if (underflow_o !== 1'b1 || pndng_i_in !== 1'b0) begin errors++; $display("FAIL uf_set: got %b/%b want 1/0", underflow_o, pndng_i_in); end
    tick();
    tick();
    tick();
    checks++; if (underflow_o !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b want 1", underflow_o); end
    // push and pop into an empty FIFO: packet is kept
    drive_req(4'd0, 4'd1, 1'b1, 1'b0, 15'h0055);
    popin = 1'b1;
    tick();
    idle();
    checks++; if (pndng_i_in !== 1'b1 || data_out_i_in !== 32'h0001_8055) begin errors++; $display("FAIL uf_push_pop: got %b/%h want 1/00018055", pndng_i_in, data_out_i_in); end
    popin = 1'b1;
    tick();
    popin = 1'b0;
    exp_sent++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      drive_req(4'd0, 4'd2, 1'b0, 1'b0, 15'(16'h0100 + i));
      tick();
    end
    idle();
    rst_i = 1'b0;
    tick();
    checks++; if (pndng_i_in !== 1'b0 || in_ready !== 1'b0 || data_out_i_in !== 32'h0) begin errors++; $display("FAIL mid_reset_outputs: got %b/%b/%h want 0/0/00000000", pndng_i_in, in_ready, data_out_i_in); end
    checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL mid_reset_underflow: got %b want 0", underflow_o); end
    rst_i = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || pndng_i_in !== 1'b0) begin errors++; $display("FAIL mid_release: got ready %b pndng %b want 1/0", in_ready, pndng_i_in); end
    tick();
    tick();
    checks++; if (pndng_i_in !== 1'b0) begin errors++; $display("FAIL mid_no_ghost: got %b want 0", pndng_i_in); end
`ifdef TERM_INJ_STATS_EN
    checks++; if (sent_cnt !== 16'd0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL mid_stats: got %0d/%0d want 0/0", sent_cnt, drop_cnt); end
`endif
    drive_req(4'd0, 4'd4, 1'b0, 1'b0, 15'h0ABC);
    tick();
    idle();
    checks++; if (data_out_i_in !== 32'h0004_0ABC) begin errors++; $display("FAIL mid_new_head: got %h want 00040abc", data_out_i_in); end
    popin = 1'b1;
    tick();
    popin = 1'b0;
    checks++; if (pndng_i_in !== 1'b0) begin errors++; $display("FAIL mid_final_empty: got %b want 0", pndng_i_in); end
  endtask

  initial begin
    idle();
    rst_i = 1'b0;
    test_reset();
    test_format();
    test_bcast();
    test_drop();
    test_fill();
    test_back_to_back();
    test_underflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
